seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider, the inverse of the combinational Multiplier in
//   the basic arithmetic set (RippleCarryAdder, Subtractor, Multiplier).

---
 rtl/seq_restoring_divider_if.sv | 28 ++
 rtl/seq_restoring_divider.sv | 116 +++++++++++
 tb/tb_seq_restoring_divider.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Bundles the start/busy/done divider handshake with its operand and result buses.
// master drives the request side, slave is the divider itself.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  // Handshake: a start seen while busy is low is accepted at the next rising edge.
  // The operands are captured at that same edge. done pulses for one cycle when the
  // results update. The results then hold until the next completion. busy and done
  // are never high together.
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// A zero divisor completes in one cycle with an all-ones quotient and the flag set.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus,
  output logic [1:0]              dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // The partial remainder stays below the divisor, so shifted < 2*divisor. The borrow
  // out of the (WIDTH+1)-bit subtraction is therefore an exact "shifted < divisor" test,
  // and a successful difference always fits in WIDTH bits.
  always_comb begin
    shifted  = {rem_q, qsh_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = ~diff[WIDTH];
    step_rem = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {qsh_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qsh_d   = qsh_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          rem_d = '0;
          qsh_d = bus.dividend;
          dvs_d = bus.divisor;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            res_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        qsh_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          quo_d   = step_quo;
          res_d   = step_rem;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      qsh_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qsh_q   <= qsh_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = res_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of seq_restoring_divider (WIDTH=4) against a
// division model, with expected results queued at each start.
module tb_seq_restoring_divider;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_total = 0;
  int         overlap_cnt = 0;
  int         k_cyc = 0;
  int         exp_off = 0;
  int         exp_busy = 0;
  int         busy_base = 0;
  logic [2*W:0] exp_q[$];

  seq_restoring_divider_if #(.WIDTH(W)) dif ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (dif),
    .dbg_state (dbg_state)
  );

  // clock / cycle bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dif.busy) busy_total <= busy_total + 1;
    if (dif.busy && dif.done) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: raise start with operands, queue the model result, drop start
  // one negedge later.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    k_cyc        = cyc + 1;
    busy_base    = busy_total;
    if (b == '0) begin
      exp_q.push_back({1'b1, {W{1'b1}}, a});
      exp_off  = 0;
      exp_busy = 0;
    end else begin
      exp_q.push_back({1'b0, W'(a / b), W'(a % b)});
      exp_off  = W;
      exp_busy = W;
    end
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    logic [2*W:0] exp;
    while (!dif.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(dif.done), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      if (dif.done) begin
        check({tag, "_result"}, 32'({dif.div_by_zero, dif.quotient, dif.remainder}), 32'(exp));
        check({tag, "_latency"}, 32'(cyc - k_cyc), 32'(exp_off));
        check({tag, "_busy_cycles"}, 32'(busy_total - busy_base), 32'(exp_busy));
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_outputs"},
          32'({dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder}), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int done_cnt;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;

    // reset state
    repeat (3) @(negedge clk);
    check_cleared("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_cleared("reset_released");

    // 13/3 and done is a single pulse with held results
    drive_start(4'd13, 4'd3);
    wait_done("d13_3");
    @(negedge clk);
    check("d13_3_pulse_end", 32'(dif.done), 32'd0);
    check("d13_3_hold_q", 32'(dif.quotient), 32'd4);

    drive_start(4'd15, 4'd1);
    wait_done("d15_1");
    drive_start(4'd3, 4'd10);
    wait_done("d3_10");
    drive_start(4'd10, 4'd5);
    wait_done("d10_5");

    // divide by zero
    drive_start(4'd6, 4'd0);
    wait_done("d6_0");
    @(negedge clk);

    // start and operand changes during RUN are ignored; start in DONE is accepted
    drive_start(4'd9, 4'd2);
    dif.start    = 1'b1;
    dif.dividend = 4'd7;
    dif.divisor  = 4'd7;
    @(negedge clk);
    dif.dividend = W'($urandom_range(0, 15));
    dif.divisor  = W'($urandom_range(0, 15));
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = W'($urandom_range(0, 15));
    dif.divisor  = W'($urandom_range(0, 15));
    wait_done("d9_2_ignore");
    drive_start(4'd7, 4'd7);
    wait_done("d7_7_b2b");
    @(negedge clk);

    // async reset mid-operation discards the operation
    drive_start(4'd13, 4'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (dif.done) done_cnt++;
    end
    check("mid_reset_no_done", 32'(done_cnt), 32'd0);
    drive_start(4'd12, 4'd4);
    wait_done("d12_4");

    // exhaustive sweep, back-to-back starts in the DONE cycle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive_start(W'(a), W'(b));
        wait_done($sformatf("sweep_%0d_%0d", a, b));
      end
    end
    @(negedge clk);

    check("busy_done_overlap", 32'(overlap_cnt), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
